// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with writeback data formatting and retired-instruction counter.
// Drives the register-file write port; rd/regWrite/data/align_err decode only the WB register.
module writeback_stage #(
    parameter int unsigned RESET_PC_LINK = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        mem_valid,
    input  logic        mem_regWrite,
    input  logic        mem_memToReg,
    input  logic        mem_link,
    input  logic [2:0]  mem_loadType,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_aluResult,
    input  logic [31:0] mem_readData,
    input  logic [31:0] mem_pc,
    output logic        wb_valid,
    output logic [4:0]  rd,
    output logic        regWrite,
    output logic [31:0] data,
    output logic        align_err,
    output logic [31:0] instret
);
    localparam int unsigned XLEN   = 32;
    localparam int unsigned RIDX_W = 5;
    localparam logic [2:0] LT_LB  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b010;
    localparam logic [2:0] LT_LH  = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;
    localparam logic [RIDX_W-1:0] LINK_REG = RIDX_W'(31);

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_to_reg;
        logic              link;
        logic [2:0]        load_type;
        logic [RIDX_W-1:0] rd;
        logic [XLEN-1:0]   alu_result;
        logic [XLEN-1:0]   read_data;
        logic [XLEN-1:0]   pc;
    } wb_t;

    wb_t             wb_q, wb_d;
    logic [XLEN-1:0] instret_q, instret_d;

    // Next-state: flush beats stall; the departing instruction retires unless it is held.
    always_comb begin
        wb_d      = wb_q;
        instret_d = instret_q;
        if (wb_q.valid && (!stall || flush)) begin
            instret_d = instret_q + XLEN'(1);
        end
        if (flush) begin
            wb_d = '0;
        end else if (!stall) begin
            wb_d.valid      = mem_valid;
            wb_d.reg_write  = mem_regWrite;
            wb_d.mem_to_reg = mem_memToReg;
            wb_d.link       = mem_link;
            wb_d.load_type  = mem_loadType;
            wb_d.rd         = mem_rd;
            wb_d.alu_result = mem_aluResult;
            wb_d.read_data  = mem_readData;
            wb_d.pc         = mem_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_q      <= '0;
            instret_q <= '0;
        end else begin
            wb_q      <= wb_d;
            instret_q <= instret_d;
        end
    end

    // Big-endian load formatting from the captured word.
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] load_data;
    always_comb begin
        byte_sel = 8'h00;
        case (wb_q.alu_result[1:0])
            2'd0:    byte_sel = wb_q.read_data[31:24];
            2'd1:    byte_sel = wb_q.read_data[23:16];
            2'd2:    byte_sel = wb_q.read_data[15:8];
            default: byte_sel = wb_q.read_data[7:0];
        endcase
        half_sel = wb_q.alu_result[1] ? wb_q.read_data[15:0] : wb_q.read_data[31:16];
        case (wb_q.load_type)
            LT_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU:  load_data = {24'h000000, byte_sel};
            LT_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            LT_LHU:  load_data = {16'h0000, half_sel};
            default: load_data = wb_q.read_data;
        endcase
    end

    // Register-file write port.
    logic              align_err_c;
    logic [RIDX_W-1:0] rd_c;
    logic              reg_write_c;
    logic [XLEN-1:0]   data_c;
    always_comb begin
        align_err_c = wb_q.valid && wb_q.mem_to_reg && !wb_q.link
                      && (wb_q.load_type == LT_LH || wb_q.load_type == LT_LHU)
                      && wb_q.alu_result[0];
        rd_c        = wb_q.link ? LINK_REG : wb_q.rd;
        reg_write_c = wb_q.valid && (wb_q.link || wb_q.reg_write) && !align_err_c
                      && (rd_c != '0);
        if (wb_q.link) begin
            data_c = wb_q.pc + XLEN'(RESET_PC_LINK);
        end else if (wb_q.mem_to_reg) begin
            data_c = load_data;
        end else begin
            data_c = wb_q.alu_result;
        end
    end

    assign wb_valid  = wb_q.valid;
    assign rd        = rd_c;
    assign regWrite  = reg_write_c;
    assign data      = data_c;
    assign align_err = align_err_c;
    assign instret   = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: a spec-level model checked every cycle plus literal expectations.
module tb_writeback_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush;
    logic        mem_valid, mem_regWrite, mem_memToReg, mem_link;
    logic [2:0]  mem_loadType;
    logic [4:0]  mem_rd;
    logic [31:0] mem_aluResult, mem_readData, mem_pc;
    logic        wb_valid, regWrite, align_err;
    logic [4:0]  rd;
    logic [31:0] data, instret;

    int total = 0;
    int bad   = 0;

    writeback_stage #(.RESET_PC_LINK(8)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_regWrite(mem_regWrite), .mem_memToReg(mem_memToReg),
        .mem_link(mem_link), .mem_loadType(mem_loadType), .mem_rd(mem_rd),
        .mem_aluResult(mem_aluResult), .mem_readData(mem_readData), .mem_pc(mem_pc),
        .wb_valid(wb_valid), .rd(rd), .regWrite(regWrite), .data(data),
        .align_err(align_err), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: the instruction sitting in WB and how many have retired.
    logic        m_v, m_rw, m_m2r, m_link;
    logic [2:0]  m_lt;
    logic [4:0]  m_rd;
    logic [31:0] m_alu, m_rdata, m_pc;
    logic [31:0] m_count;
    logic [31:0] m_base = 32'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            {m_v, m_rw, m_m2r, m_link} = 4'b0;
            m_lt = 3'd0; m_rd = 5'd0; m_alu = 32'd0; m_rdata = 32'd0; m_pc = 32'd0;
            m_count = 32'd0;
        end else begin
            if (m_v && (flush || !stall)) m_count = m_count + 32'd1;
            if (flush) m_v = 1'b0;
            else if (!stall) begin
                m_v = mem_valid; m_rw = mem_regWrite; m_m2r = mem_memToReg; m_link = mem_link;
                m_lt = mem_loadType; m_rd = mem_rd; m_alu = mem_aluResult;
                m_rdata = mem_readData; m_pc = mem_pc;
            end
        end
    end

    function automatic logic [31:0] fmt_load(input logic [2:0] lt, input logic [1:0] a,
                                             input logic [31:0] w);
        logic [31:0] b, h;
        int unsigned bshift, hshift;
        bshift = 8 * (3 - int'(a));
        hshift = (a >= 2'd2) ? 0 : 16;
        b = (w >> bshift) & 32'h0000_00FF;
        h = (w >> hshift) & 32'h0000_FFFF;
        case (lt)
            3'd1:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
            3'd2:    return b;
            3'd3:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            3'd4:    return h;
            default: return w;
        endcase
    endfunction

    // Per-cycle compare against the model, away from the rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            logic        e_al, e_we;
            logic [4:0]  e_rd;
            logic [31:0] e_data;
            e_al   = m_v && m_m2r && !m_link && (m_lt == 3'd3 || m_lt == 3'd4) && m_alu[0];
            e_rd   = m_link ? 5'd31 : m_rd;
            e_we   = m_v && (m_link || m_rw) && !e_al && (e_rd != 5'd0);
            e_data = m_link ? m_pc + 32'd8 : (m_m2r ? fmt_load(m_lt, m_alu[1:0], m_rdata) : m_alu);
            chk("model.wb_valid", 32'(wb_valid), 32'(m_v));
            chk("model.regWrite", 32'(regWrite), 32'(e_we));
            chk("model.align_err", 32'(align_err), 32'(e_al));
            chk("model.instret", instret, m_count + m_base);
            if (e_we) begin
                chk("model.rd", 32'(rd), 32'(e_rd));
                chk("model.data", data, e_data);
            end
        end
    end

    task automatic set_in(input logic v, input logic rw, input logic m2r, input logic lk,
                          input logic [2:0] lt, input logic [4:0] r, input logic [31:0] alu,
                          input logic [31:0] rdat, input logic [31:0] pc);
        mem_valid = v; mem_regWrite = rw; mem_memToReg = m2r; mem_link = lk;
        mem_loadType = lt; mem_rd = r; mem_aluResult = alu; mem_readData = rdat; mem_pc = pc;
    endtask

    // Apply inputs at a falling edge, let one rising edge capture them, return at next falling edge.
    task automatic step(input logic st, input logic fl);
        stall = st; flush = fl;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    localparam logic [31:0] RDW = 32'h80FF_7F01;

    initial begin
        logic [31:0] ic;
        logic [4:0]  hold_rd;
        logic [31:0] hold_data;
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        set_in(0, 0, 0, 0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        #2;
        chk("reset.wb_valid", 32'(wb_valid), 32'd0);
        chk("reset.data", data, 32'd0);
        chk("reset.rd", 32'(rd), 32'd0);
        chk("reset.instret", instret, 32'd0);
        @(negedge clk); rst = 1'b0;

        // ALU write, then reset mid-cycle while it sits in WB.
        set_in(1, 1, 0, 0, 3'd0, 5'd5, 32'h1234_5678, 32'd0, 32'h100); step(0, 0);
        chk("alu.rd", 32'(rd), 32'd5);
        chk("alu.regWrite", 32'(regWrite), 32'd1);
        chk("alu.data", data, 32'h1234_5678);
        @(posedge clk); #2 rst = 1'b1; #1;
        chk("midreset.wb_valid", 32'(wb_valid), 32'd0);
        chk("midreset.regWrite", 32'(regWrite), 32'd0);
        chk("midreset.data", data, 32'd0);
        chk("midreset.rd", 32'(rd), 32'd0);
        @(negedge clk);
        chk("midreset.nowrite", 32'(regWrite), 32'd0);
        chk("midreset.instret", instret, 32'd0);
        rst = 1'b0;

        set_in(1, 1, 0, 0, 3'd0, 5'd5, 32'h1234_5678, 32'd0, 32'h100); step(0, 0);
        chk("alu2.data", data, 32'h1234_5678);
        chk("alu2.instret", instret, 32'd0);
        set_in(1, 1, 0, 0, 3'd0, 5'd0, 32'h1234_5678, 32'd0, 32'h104); step(0, 0);
        chk("rd0.regWrite", 32'(regWrite), 32'd0);
        chk("rd0.instret", instret, 32'd1);

        // Loads from the same word at various offsets.
        set_in(1, 1, 1, 0, 3'd1, 5'd8, 32'h0000_1000, RDW, 32'h108); step(0, 0);
        chk("lb0.data", data, 32'hFFFF_FF80);
        set_in(1, 1, 1, 0, 3'd2, 5'd8, 32'h0000_1001, RDW, 32'h10C); step(0, 0);
        chk("lbu1.data", data, 32'h0000_00FF);
        set_in(1, 1, 1, 0, 3'd1, 5'd8, 32'h0000_1003, RDW, 32'h110); step(0, 0);
        chk("lb3.data", data, 32'h0000_0001);
        set_in(1, 1, 1, 0, 3'd3, 5'd9, 32'h0000_1002, RDW, 32'h114); step(0, 0);
        chk("lh2.data", data, 32'h0000_7F01);
        set_in(1, 1, 1, 0, 3'd4, 5'd9, 32'h0000_1000, RDW, 32'h118); step(0, 0);
        chk("lhu0.data", data, 32'h0000_80FF);
        set_in(1, 1, 1, 0, 3'd3, 5'd9, 32'h0000_1000, RDW, 32'h11C); step(0, 0);
        chk("lh0.data", data, 32'hFFFF_80FF);
        set_in(1, 1, 1, 0, 3'd3, 5'd9, 32'h0000_1001, RDW, 32'h120); step(0, 0);
        chk("lh1.align_err", 32'(align_err), 32'd1);
        chk("lh1.regWrite", 32'(regWrite), 32'd0);
        set_in(1, 1, 1, 0, 3'd0, 5'd10, 32'h0000_1003, RDW, 32'h124); step(0, 0);
        chk("lw3.data", data, RDW);
        chk("lw3.align_err", 32'(align_err), 32'd0);
        set_in(1, 1, 1, 0, 3'd7, 5'd10, 32'h0000_1001, RDW, 32'h128); step(0, 0);
        chk("lt7.data", data, RDW);

        // Link overrides rd and data even with regWrite clear.
        set_in(1, 0, 1, 1, 3'd3, 5'd0, 32'h0000_0001, RDW, 32'h0040_0010); step(0, 0);
        chk("jal.rd", 32'(rd), 32'd31);
        chk("jal.data", data, 32'h0040_0018);
        chk("jal.regWrite", 32'(regWrite), 32'd1);
        chk("jal.align_err", 32'(align_err), 32'd0);

        // Bubble, then a write held by a 3-cycle stall.
        set_in(0, 1, 0, 0, 3'd0, 5'd4, 32'hDEAD_BEEF, 32'd0, 32'h130); step(0, 0);
        chk("bubble.wb_valid", 32'(wb_valid), 32'd0);
        chk("bubble.regWrite", 32'(regWrite), 32'd0);
        set_in(1, 1, 0, 0, 3'd0, 5'd7, 32'h0000_AAAA, 32'd0, 32'h134); step(0, 0);
        ic = instret; hold_rd = rd; hold_data = data;
        set_in(1, 1, 0, 0, 3'd0, 5'd12, 32'h5555_0000, 32'd0, 32'h138);
        for (int i = 0; i < 3; i++) begin
            step(1, 0);
            chk("stall.rd", 32'(rd), 32'(hold_rd));
            chk("stall.data", data, hold_data);
            chk("stall.instret", instret, ic);
        end
        chk("stall.data_lit", data, 32'h0000_AAAA);
        step(1, 1);
        chk("stallflush.wb_valid", 32'(wb_valid), 32'd0);
        chk("stallflush.instret", instret, ic + 32'd1);
        step(0, 0);
        chk("after_flush.data", data, 32'h5555_0000);

        // Counter wrap: preload near the top, then retire one instruction.
        @(posedge clk); #2;
        force dut.instret_q = 32'hFFFF_FFFF;
        m_base = 32'hFFFF_FFFF - m_count;
        #1 release dut.instret_q;
        @(negedge clk); #1;
        chk("wrap.pre", instret, 32'hFFFF_FFFF);
        step(0, 0);
        chk("wrap.instret", instret, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/writeback_stage.md
# writeback_stage

MEM/WB pipeline register and writeback datapath of the five-stage MIPS pipeline. Captures the MEM-stage result each cycle, selects and formats the value to retire (ALU result, aligned and extended load data, or link address), and drives the register file write port (`rd`, `regWrite`, `data`). It also counts retired instructions. The register file commits on the falling edge of the same cycle, so a write is visible to decode within the cycle it appears at this block's outputs.

## Interface
Parameters:
- `RESET_PC_LINK`, 8: byte offset added to `mem_pc` for link writes (PC+8).

Ports:
- `clk` input 1: pipeline clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `stall` input 1: hold the MEM/WB register contents.
- `flush` input 1: replace the captured instruction with a bubble.
- `mem_valid` input 1: MEM stage holds a real instruction.
- `mem_regWrite` input 1: the instruction writes a register.
- `mem_memToReg` input 1: the write data comes from the load path.
- `mem_link` input 1: jal/jalr; write the link address.
- `mem_loadType` input 3: 000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu, 101–111 reserved (treated as lw).
- `mem_rd` input 5: destination register.
- `mem_aluResult` input 32: ALU result or effective address.
- `mem_readData` input 32: raw word from data memory.
- `mem_pc` input 32: instruction PC.
- `wb_valid` output 1: the WB register holds a real instruction.
- `rd` output 5: register-file write index.
- `regWrite` output 1: register-file write enable.
- `data` output 32: register-file write data; also the forwarding source.
- `align_err` output 1: misaligned halfword load in WB.
- `instret` output 32: retired-instruction counter.

## Operation
- WB register fields: valid, regWrite, memToReg, link, loadType, rd, aluResult, readData, pc.
- Rising-edge update priority: `rst` > `flush` > `stall` > capture.
  - flush: valid←0; other fields don't-care, and outputs must not write.
  - stall: all fields hold.
  - capture: all fields ← `mem_*`.
- Destination: `rd` = 31 if link, else the captured rd.
- Data select priority: link, then memToReg, then ALU.
  - link: `data` = pc + `RESET_PC_LINK`, mod 2^32.
  - memToReg: load-formatted data.
  - else: aluResult.
- Load formatting is big-endian. With a = aluResult[1:0]:
  - lb/lbu: byte a=0 → readData[31:24], a=1 → [23:16], a=2 → [15:8], a=3 → [7:0]. Sign-extend for lb, zero-extend for lbu.
  - lh/lhu: a[1]=0 → [31:16], a[1]=1 → [15:0]. Sign- or zero-extend accordingly.
  - lw and reserved codes: readData unchanged. aluResult[1:0] is ignored for lw.
- `align_err` = valid & memToReg & ~link & (loadType ∈ {011,100}) & a[0].
- `regWrite` = valid & (link | captured regWrite) & ~align_err & (`rd` ≠ 0).
- When `regWrite`=0, `data` and `rd` are don't-care, except after reset (see Timing).
- `instret` increments by 1 at each rising edge where `wb_valid`=1, `stall`=0 and `rst`=0. This counts the instruction leaving WB, whether or not it writes a register. Wraps 0xFFFFFFFF → 0.
- A flush in a cycle where WB holds a valid instruction still retires that instruction, so `instret` increments. The flush affects only the incoming slot.

## Timing
- Reset (async, immediate): `wb_valid`=0, `rd`=0, `regWrite`=0, `data`=0, `align_err`=0, `instret`=0. All WB fields are cleared.
- Reset asserted mid-operation drops the in-flight instruction with no write and no count. The first capture happens at the first rising edge after `rst` deasserts.
- Latency: `mem_*` values sampled at rising edge N appear on the outputs after edge N. The register file commits them at the falling edge inside cycle N, so decode reads the new value in the second half of that cycle.
- `rd`, `regWrite`, `data` and `align_err` are combinational from the WB register only, with no path from `mem_*`.
- Stall holds the outputs; the register file rewrites the same value each falling edge, which is harmless.
- Stall and flush together: flush wins and a bubble is captured.

## Test plan
- Reset: assert `rst` mid-cycle with a valid add in WB → all outputs 0 immediately; no write at the next falling edge; `instret`=0.
- ALU write: capture rd=5, aluResult=0x1234_5678, regWrite=1 → next cycle `rd`=5, `regWrite`=1, `data`=0x12345678. Same instruction with rd=0 → `regWrite`=0.
- Byte and halfword loads:
  - readData=0x80FF_7F01, lb at a=0 → `data`=0xFFFFFF80.
  - lbu at a=1 → 0x000000FF.
  - lh at a=2 → 0x00007F01.
  - lhu at a=0 → 0x000080FF.
  - lh at a=1 → `align_err`=1, `regWrite`=0.
- Link: jal, pc=0x0040_0010, mem_rd=0 → `rd`=31, `data`=0x00400018, `regWrite`=1.
- Stall/flush: stall 3 cycles with a valid write → outputs constant and `instret` unchanged. Stall+flush together → bubble enters WB (`wb_valid`=0), and `instret` increments once for the departing instruction.
- Counter wrap: force `instret`=0xFFFFFFFF via 2^32−1 retirements (or preload in sim) → one more retirement gives 0.
